// File: rtl/mavg_axis_packetizer.sv
// Buffers moving-average filter samples in a FIFO and emits them as an AXI4-Stream master,
// framing packets with tlast every packet_len words and counting samples lost to backpressure.
module mavg_axis_packetizer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  packet_len,
  input  logic                  clear_status,
  input  logic                  in_data_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  overflow,
  output logic [15:0]           drop_count,
  output logic [FIFO_AW:0]      fifo_level
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [FIFO_AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]      level_q, level_d;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q, tlast_q;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, len_q, len_d, len_eff;
  logic                  last_d, new_pkt;
  logic                  overflow_q;
  logic [15:0]           drop_q;
  logic                  empty, full, push, pop, drop, drain_final;

  assign empty = (level_q == '0);
  assign full  = level_q[FIFO_AW];
  assign pop   = !empty && (!tvalid_q || m_axis_tready);
  // A full FIFO still accepts a sample when a word leaves in the same cycle.
  assign push  = in_data_valid && enable && (!full || pop);
  assign drop  = in_data_valid && enable && !push;
  // Draining with this word being the last one left: close the packet short.
  assign drain_final = !enable && pop && (level_q == {{FIFO_AW{1'b0}}, 1'b1});

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Framing FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Framing FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop && !drain_final) state_d = StRun;
      StRun: begin
        if (drain_final)              state_d = StIdle;
        else if (!enable && !empty)   state_d = StDrain;
      end
      StDrain: begin
        if (enable)                   state_d = StRun;
        else if (drain_final)         state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Framing FSM: outputs (packet counter update and tlast for the word being loaded)
  always_comb begin
    new_pkt = (state_q == StIdle) || (cnt_q == len_q);
    len_eff = len_q;
    cnt_d   = cnt_q;
    if (new_pkt) len_eff = (packet_len == '0) ? LEN_WIDTH'(1) : packet_len;
    if (pop)     cnt_d   = new_pkt ? LEN_WIDTH'(1) : cnt_q + 1'b1;
    len_d  = pop ? len_eff : len_q;
    last_d = (cnt_d == len_eff) || drain_final;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
      if (pop) begin
        tvalid_q <= 1'b1;
        tdata_q  <= mem_q[rd_ptr_q];
        tlast_q  <= last_d;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  // Clear takes priority over a drop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (clear_status) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign overflow      = overflow_q;
  assign drop_count    = drop_q;
  assign fifo_level    = level_q;

endmodule
